// File: rtl/vid_timing_pkg.sv
// Shared definitions for the video timing generator.
//   region_e    : raster region of one axis (active, front porch, sync, back porch)
//   vid_mode_t  : region lengths of a complete video mode
//   MODE_*      : standard mode constants (1280x1024@60 is the default mode)
//   axis_total  : sum of the four region lengths of one axis
package vid_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FP,
    SYNC,
    BP
  } region_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vid_mode_t;

  localparam vid_mode_t MODE_1280X1024_60 = '{
    h_active: 1280, h_fp: 48, h_sync: 112, h_bp: 248,
    v_active: 1024, v_fp: 1,  v_sync: 3,   v_bp: 38
  };

  localparam vid_mode_t MODE_1024X768_60 = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29
  };

  localparam vid_mode_t MODE_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync_len,
                                             input int unsigned bp);
    return active + fp + sync_len + bp;
  endfunction

endpackage

// File: rtl/vid_axis_cntr.sv
// One raster axis: a position counter that advances on step_i and wraps
// after the last back-porch position, plus a decode of the current region.
//   clk, rst  : clock, asynchronous active-high reset
//   step_i    : advance the position by one
//   wrap_o    : step_i while at the last position (position returns to 0)
//   pos_o     : current position, 0 = first active pixel/line
//   region_o  : region containing pos_o
module vid_axis_cntr
  import vid_timing_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter int unsigned LEN_ACTIVE = 1,
  parameter int unsigned LEN_FP     = 0,
  parameter int unsigned LEN_SYNC   = 1,
  parameter int unsigned LEN_BP     = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_i,
  output logic         wrap_o,
  output logic [W-1:0] pos_o,
  output region_e      region_o
);

  localparam int unsigned TOTAL      = axis_total(LEN_ACTIVE, LEN_FP, LEN_SYNC, LEN_BP);
  localparam int unsigned SYNC_START = LEN_ACTIVE + LEN_FP;
  localparam int unsigned BP_START   = SYNC_START + LEN_SYNC;
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

  if (LEN_ACTIVE < 1 || LEN_SYNC < 1) begin : g_len_err
    $error("vid_axis_cntr: active and sync lengths must be at least 1");
  end
  if (TOTAL > (32'd1 << W)) begin : g_width_err
    $error("vid_axis_cntr: axis total does not fit the position width");
  end

  logic [W-1:0] pos_q, pos_d;
  logic         at_last;
  int unsigned  pos_ext;

  always_comb begin
    at_last = (pos_q == LAST);
    wrap_o  = step_i && at_last;
    pos_d   = pos_q;
    if (step_i) begin
      pos_d = at_last ? '0 : pos_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  // Region boundaries are compared at 32 bits: the back-porch start may equal
  // 2**W when the back porch is empty.
  always_comb begin
    pos_ext = 32'(pos_q);
    if (pos_ext < LEN_ACTIVE) begin
      region_o = ACTIVE;
    end else if (pos_ext < SYNC_START) begin
      region_o = FP;
    end else if (pos_ext < BP_START) begin
      region_o = SYNC;
    end else begin
      region_o = BP;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator: raster pixel-request stream plus monitor sync pins.
//   clk, reset     : pixel clock, asynchronous active-high reset
//   tg_en          : timing enable; low freezes the raster and blanks requests
//   out_req/out_de : high for each active pixel
//   out_eol/out_eof: last active pixel of a line / of the frame (only with req)
//   out_vsync      : active-high vertical sync for the pixel stream
//   vid_hsync/vid_vsync : monitor sync pins with HS_POL/VS_POL applied
//   h_pos, v_pos   : current raster position
// Flags and pins are registered from the position held before each edge, so
// they trail h_pos/v_pos by one cycle.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_1280X1024_60.h_active,
  parameter int unsigned H_FP     = MODE_1280X1024_60.h_fp,
  parameter int unsigned H_SYNC   = MODE_1280X1024_60.h_sync,
  parameter int unsigned H_BP     = MODE_1280X1024_60.h_bp,
  parameter int unsigned V_ACTIVE = MODE_1280X1024_60.v_active,
  parameter int unsigned V_FP     = MODE_1280X1024_60.v_fp,
  parameter int unsigned V_SYNC   = MODE_1280X1024_60.v_sync,
  parameter int unsigned V_BP     = MODE_1280X1024_60.v_bp,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tg_en,
  output logic        out_vsync,
  output logic        out_req,
  output logic        out_eol,
  output logic        out_eof,
  output logic        out_de,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic [11:0] h_pos,
  output logic [10:0] v_pos
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [11:0] H_LAST_ACT = 12'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST_ACT = 11'(V_ACTIVE - 1);

  if (H_TOTAL > 4096) begin : g_h_total_err
    $error("vid_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 2048) begin : g_v_total_err
    $error("vid_timing_gen: V_TOTAL exceeds 2048");
  end

  logic    h_wrap;
  region_e h_region, v_region;

  vid_axis_cntr #(
    .W(12), .LEN_ACTIVE(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP)
  ) u_h_cntr (
    .clk(clk), .rst(reset), .step_i(tg_en),
    .wrap_o(h_wrap), .pos_o(h_pos), .region_o(h_region)
  );

  vid_axis_cntr #(
    .W(11), .LEN_ACTIVE(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP)
  ) u_v_cntr (
    .clk(clk), .rst(reset), .step_i(h_wrap),
    .wrap_o(), .pos_o(v_pos), .region_o(v_region)
  );

  logic req_d, eol_d, eof_d, hs_act_d, vs_act_d;
  logic req_q, eol_q, eof_q, vsync_q, hs_pin_q, vs_pin_q;

  always_comb begin
    req_d    = (h_region == ACTIVE) && (v_region == ACTIVE);
    eol_d    = req_d && (h_pos == H_LAST_ACT);
    eof_d    = eol_d && (v_pos == V_LAST_ACT);
    hs_act_d = (h_region == SYNC);
    vs_act_d = (v_region == SYNC);
  end

  // While disabled the request flags are cleared but sync levels are kept,
  // so the monitor sees a frozen, still-valid sync state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      vsync_q  <= 1'b0;
      hs_pin_q <= ~HS_POL;
      vs_pin_q <= ~VS_POL;
    end else if (tg_en) begin
      req_q    <= req_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      vsync_q  <= vs_act_d;
      hs_pin_q <= hs_act_d ? HS_POL : ~HS_POL;
      vs_pin_q <= vs_act_d ? VS_POL : ~VS_POL;
    end else begin
      req_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
    end
  end

  assign out_req   = req_q;
  assign out_de    = req_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign out_vsync = vsync_q;
  assign vid_hsync = hs_pin_q;
  assign vid_vsync = vs_pin_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen in the 8x6 raster (H 4/1/2/1, V 3/1/1/1).
// Cycle n counts clock edges since reset release. Without pauses, the flags
// for raster index L = v*8+h appear at cycle L+1, so a frame is 48 cycles:
// pixels at v*8+h+1 (h<4, v<3), hsync high at cycles line*8+6..+7, vsync
// high at cycles 33..40 of each frame. A pause shifts every later event.
module tb_vid_timing_gen;

  logic        clk = 1'b0, reset = 1'b0, tg_en = 1'b0;
  logic        out_vsync, out_req, out_eol, out_eof, out_de, vid_hsync, vid_vsync;
  logic [11:0] h_pos;
  logic [10:0] v_pos;
  logic        p0_out_vsync, p0_req, p0_eol, p0_eof, p0_de, p0_hsync, p0_vsync;
  logic [11:0] p0_h_pos;
  logic [10:0] p0_v_pos;

  vid_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .tg_en(tg_en),
    .out_vsync(out_vsync), .out_req(out_req), .out_eol(out_eol), .out_eof(out_eof),
    .out_de(out_de), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
    .h_pos(h_pos), .v_pos(v_pos)
  );

  vid_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_pol0 (
    .clk(clk), .reset(reset), .tg_en(tg_en),
    .out_vsync(p0_out_vsync), .out_req(p0_req), .out_eol(p0_eol), .out_eof(p0_eof),
    .out_de(p0_de), .vid_hsync(p0_hsync), .vid_vsync(p0_vsync),
    .h_pos(p0_h_pos), .v_pos(p0_v_pos)
  );

  typedef struct {
    int cyc;
    bit eol;
    bit eof;
    int hc;
    int vc;
  } pix_t;

  typedef struct {
    int cyc;
    bit hs;
    bit vs;
  } syn_t;

  pix_t pix_q[$];
  syn_t syn_q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc = reset ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Queue the expected pixel and sync-change events of `frames` frames.
  // Events at nominal cycle >= shift_from move later by shift_len; events
  // landing after `last` are not expected.
  task automatic plan(input int frames, input int shift_from, input int shift_len,
                      input int last);
    bit hs = 1'b0;
    bit vs = 1'b0;
    int c;
    for (int n = 1; n <= frames * 48; n++) begin
      int h;
      int v;
      h = (n - 1) % 8;
      v = ((n - 1) / 8) % 6;
      c = n + ((shift_from > 0 && n >= shift_from) ? shift_len : 0);
      if (c > last) break;
      if (h < 4 && v < 3) pix_q.push_back('{c, (h == 3), (h == 3 && v == 2), h, v});
      if (n % 8 == 6 || n % 8 == 0 || n % 48 == 33 || n % 48 == 41) begin
        if (n % 8 == 6)   hs = 1'b1;
        if (n % 8 == 0)   hs = 1'b0;
        if (n % 48 == 33) vs = 1'b1;
        if (n % 48 == 41) vs = 1'b0;
        syn_q.push_back('{c, hs, vs});
      end
    end
  endtask

  // Monitor: downstream pixel counter driven by the DUT stream, plus
  // scoreboard pops on each request and on each sync-pin change.
  int         hc = 0, vc = 0;
  logic [4:0] prev = 5'b00011;
  logic [4:0] cur;
  pix_t       pe;
  syn_t       se;

  always @(negedge clk) begin
    if (reset) begin
      hc   = 0;
      vc   = 0;
      prev = 5'b00011;
    end else begin
      if (out_req) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got req at cycle %0d expected none", cyc);
        end else begin
          pe = pix_q.pop_front();
          chk("req_cycle", cyc, pe.cyc);
          chk("eol", out_eol, pe.eol);
          chk("eof", out_eof, pe.eof);
          chk("de", out_de, 1);
          chk("dn_h_cntr", hc, pe.hc);
          chk("dn_v_cntr", vc, pe.vc);
        end
        if (out_eof) begin
          hc = 0;
          vc = 0;
        end else if (out_eol) begin
          hc = 0;
          vc++;
        end else begin
          hc++;
        end
      end else begin
        chk("idle_eol_eof_de", {out_eol, out_eof, out_de}, 0);
      end
      if (out_vsync) begin
        hc = 0;
        vc = 0;
      end
      cur = {vid_hsync, vid_vsync, out_vsync, p0_hsync, p0_vsync};
      if (cur !== prev) begin
        if (syn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sync_unexpected: got sync change %b at cycle %0d expected none", cur, cyc);
        end else begin
          se = syn_q.pop_front();
          chk("sync_cycle", cyc, se.cyc);
          chk("hsync", vid_hsync, se.hs);
          chk("vsync_pin", vid_vsync, se.vs);
          chk("out_vsync", out_vsync, se.vs);
          chk("hsync_pol0", p0_hsync, !se.hs);
          chk("vsync_pol0", p0_vsync, !se.vs);
          chk("out_vsync_pol0", p0_out_vsync, se.vs);
        end
        prev = cur;
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, out_req, 0);
    chk({tag, "_eol_eof_de"}, {out_eol, out_eof, out_de}, 0);
    chk({tag, "_out_vsync"}, out_vsync, 0);
    chk({tag, "_pos"}, {h_pos, v_pos}, 0);
    chk({tag, "_hsync"}, vid_hsync, 0);
    chk({tag, "_vsync"}, vid_vsync, 0);
    chk({tag, "_hsync_pol0"}, p0_hsync, 1);
    chk({tag, "_vsync_pol0"}, p0_vsync, 1);
  endtask

  initial begin
    #1 reset = 1'b1;
    #3 chk_reset_state("reset");
    // Four frames; tg_en drops for cycles 107..111 with (h,v)=(2,1) held.
    plan(4, 107, 5, 159);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    tg_en = 1'b1;

    while (cyc < 106) @(negedge clk);
    #2 tg_en = 1'b0;
    while (cyc < 109) @(negedge clk);
    #1 chk("pause_pos", {h_pos, v_pos}, {12'd2, 11'd1});
    chk("pause_req", out_req, 0);
    while (cyc < 111) @(negedge clk);
    #2 tg_en = 1'b1;

    // Frame 4 is at (h,v)=(2,1) here; reset asynchronously mid-line.
    while (cyc < 159) @(negedge clk);
    #1 chk("pix_q_drained_pre_reset", pix_q.size(), 0);
    chk("syn_q_drained_pre_reset", syn_q.size(), 0);
    chk("pre_reset_req", out_req, 1);
    #1 reset = 1'b1;
    #1 chk_reset_state("mid_reset");

    plan(1, 0, 0, 47);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    while (cyc < 47) @(negedge clk);
    #2 chk("pix_q_drained_end", pix_q.size(), 0);
    chk("syn_q_drained_end", syn_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Video timing generator. Produces the raster pixel-request stream (vsync, req, eol, eof) that feeds the downstream pixel counter and pixel fetch logic.
- Also drives monitor-side hsync/vsync/de pins.
- Sits at the head of the video pipeline, in the pixel clock domain.
- Free-running; pauses only when tg_en is low.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_ACTIVE, 1024, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- HS_POL, 1, hsync pin active level
- VS_POL, 1, vsync pin active level

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- tg_en  in  1  timing enable; low freezes the raster
- out_vsync  out  1  active-high vertical sync for the pixel stream, polarity-independent
- out_req  out  1  pixel request, high for each active pixel
- out_eol  out  1  last active pixel of a line; only with out_req
- out_eof  out  1  last active pixel of the frame; only with out_req
- out_de  out  1  display enable, equal to out_req
- vid_hsync  out  1  hsync pin, HS_POL applied
- vid_vsync  out  1  vsync pin, VS_POL applied
- h_pos  out  12  current horizontal position, 0..H_TOTAL-1
- v_pos  out  11  current vertical position, 0..V_TOTAL-1

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the vertical equivalent.
- Elaboration error if H_TOTAL > 4096 or V_TOTAL > 2048.
- Region order per axis: active, front porch, sync, back porch. Position 0 is the first active pixel/line.
- h_pos increments each enabled clock and wraps at H_TOTAL-1 to 0.
- v_pos increments when h_pos wraps, and wraps at V_TOTAL-1 to 0.
- All outputs are registered. They reflect the counter state from the previous cycle: 1-cycle latency from (h_pos, v_pos) to the flags.
- out_req = h_pos < H_ACTIVE && v_pos < V_ACTIVE.
- out_eol = out_req && h_pos == H_ACTIVE-1.
- out_eof = out_eol && v_pos == V_ACTIVE-1.
- Horizontal sync is active when H_ACTIVE+H_FP <= h_pos < H_ACTIVE+H_FP+H_SYNC. vid_hsync = HS_POL when active, else !HS_POL.
- Vertical sync is active when V_ACTIVE+V_FP <= v_pos < V_ACTIVE+V_FP+V_SYNC. It spans whole lines and changes at h_pos == 0.
- out_vsync is active high whenever vertical sync is active. vid_vsync = VS_POL when active, else !VS_POL.
- Reset (async assert):
  - h_pos = 0, v_pos = 0.
  - out_req/eol/eof/de/vsync = 0.
  - vid_hsync = !HS_POL, vid_vsync = !VS_POL.
- Reset release: the first clk edge registers the flags for (0,0), so out_req is high 1 cycle after reset deasserts.
- Reset mid-frame: immediate return to the reset state. The next frame restarts at (0,0) with no partial-frame completion.
- tg_en low:
  - Counters hold.
  - out_req/eol/eof/de are forced 0 on the next edge.
  - Sync outputs hold their current level.
- tg_en re-high: resumes from the held position. The flags for that position appear 1 cycle later.
- The downstream consumer is reset by out_vsync, or at eof with req. Every frame therefore delivers exactly V_ACTIVE eol pulses and 1 eof pulse.
- With V_FP = 0, vertical sync starts on the line immediately after the last active line. This is legal.
- H_FP, H_BP and V_BP may each be 0. H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be >= 1.

Decomposition:
- Package vid_timing_pkg holds:
  - constants for standard modes: 1280x1024@60 (the defaults), 1024x768@60, 640x480@60;
  - the region enum {ACTIVE, FP, SYNC, BP};
  - a function computing totals.
- One sub-module, vid_axis_cntr, is natural and is instantiated twice (h and v axes). It is parameterized by the four region lengths.
- vid_axis_cntr ports: step input, wrap output, pos, region.
- The horizontal wrap drives the vertical step.

Test Plan:
All scenarios use the small mode H=4/1/2/1 (H_TOTAL=8) and V=3/1/1/1 (V_TOTAL=6), giving a 48-clock frame.
- Reset release -> out_req=1 at cycle 1. Per line: 4 req per line, out_eol on the 4th, vid_hsync active for exactly 2 clocks starting 5 clocks after the line starts. Per frame: 12 req, 3 eol, 1 eof.
- Frame periodicity -> out_eof exactly every 48 clocks. out_vsync high for 8 consecutive clocks (v_pos=4) and low for the other 40.
- Polarity: HS_POL=0, VS_POL=0 -> vid_hsync/vid_vsync are inverted relative to POL=1. out_vsync is unchanged (active high).
- tg_en low for 5 clocks mid-line at h_pos=2 -> req drops 1 cycle later. Position holds. After re-enable, the remaining 2 req and the eol appear. Per-frame totals are unchanged and the frame is stretched by 5 clocks.
- Async reset asserted mid-active-line (v_pos=1, h_pos=2) -> outputs go to reset values without a clock edge. After release the frame restarts at (0,0).
- Connect the output stream to the downstream pixel counter -> its h_cntr reaches 3 at eol, its v_cntr reaches 2 before eof, and both return to 0 at eof and during vsync.
